i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
I2S master transmitter. Generates sck/ws from the system clock and serializes one stereo pair of DATA_W-bit samples per 64-sck frame, MSB first, in standard I2S format with a one-sck delay after each ws edge. Sits between the DSP output path and an external I2S DAC/codec. It uses the same frame geometry as the microphone receive path (32 sck per channel slot, 64 per frame) so both ends can share sck/ws timing.

Parameters:
CLK_DIV, 32, clk cycles per sck period; even, >= 4 (100 MHz / 32 = 3.125 MHz sck).
DATA_W, 16, sample width per channel; must be <= 31.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  transmit enable; when low, the interface idles
l_data  input  DATA_W  left-channel sample
r_data  input  DATA_W  right-channel sample
din_vld  input  1  l_data/r_data valid
din_rdy  output  1  holding buffer empty; a pair is accepted when din_vld & din_rdy
sck  output  1  serial clock, registered
ws  output  1  word select, registered; 0 = left, 1 = right
sd  output  1  serial data, registered; changes only with sck falling
frame_start  output  1  one-clk pulse when a frame loads into the shift registers
underflow  output  1  one-clk pulse when a frame starts with the holding buffer empty

Behaviour:
- Reset (rst=1 at a clk edge):
  - div_cnt=0, bit_cnt=63.
  - sck=0, ws=0, sd=0, frame_start=0, underflow=0.
  - Holding buffer empty (din_rdy=1); shift registers cleared.
  - Reset mid-frame aborts the frame immediately; the buffered pair is discarded.
- en=0: same register values as reset, except the holding buffer and din_rdy are preserved, so input can be preloaded while disabled.
- Divider: with en=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - sck register <= 1 on the edge where div_cnt goes CLK_DIV/2-1 -> CLK_DIV/2.
  - sck register <= 0 on the wrap edge CLK_DIV-1 -> 0. This wrap edge is the "bit advance" event.
- Bit advance: bit_cnt <= bit_cnt+1 mod 64. sd, ws and sck all update on this same clk edge.
- ws <= 1 when the new bit_cnt is in 31..62; ws <= 0 when it is in 63 or 0..30. ws therefore changes one sck before each channel MSB.
- sd for the new bit_cnt b:
  - b in 0..DATA_W-1: left bit [DATA_W-1-b].
  - b in 32..32+DATA_W-1: right bit [DATA_W-1-(b-32)].
  - All other b: 0.
- Frame load: on the bit advance where bit_cnt wraps 63 -> 0:
  - If the buffer is full: copy the buffer to the left/right shift registers, mark the buffer empty, pulse frame_start.
  - If the buffer is empty: load zeros, pulse both frame_start and underflow.
- Handshake: din_rdy = ~buffer_full, registered.
  - Accept on din_vld & din_rdy; the buffer becomes full the next cycle.
  - In a load cycle, the buffer empties and din_rdy=1 on the following cycle. No same-cycle accept-and-load: din_rdy is 0 while the buffer is full.
  - Data is sampled only on the accept edge; later changes on l_data/r_data are ignored.
- First frame after en rises (reset state): div_cnt starts counting in the en=1 cycle.
  - sck rises CLK_DIV/2 clks later, in bit slot 63 with ws=0, sd=0.
  - The first bit advance, CLK_DIV clks after en rose, starts frame 0 and presents the left MSB.
- en dropped mid-frame: the next clk edge forces the idle values; the partially sent frame is lost.
- Steady state: exactly 64 sck periods per frame, 50% sck duty, and no glitches on sck, ws or sd. Each changes at most once per clk.

Test Plan:
1. CLK_DIV=4. Reset, en=1, push L=16'hA5C3, R=16'h0F01 before the first frame. Sample sd on sck rising: bits 0..15 = A5C3 MSB-first, 16..31 = 0, 32..47 = 0F01, 48..63 = 0. ws rises at bit 31 and falls at bit 63. frame_start pulses once. underflow=0.
2. Never assert din_vld, en=1 for 3 frames -> sd constant 0, and frame_start and underflow each pulse 3 times at 256-clk spacing (CLK_DIV=4).
3. Back-to-back streaming: din_vld held high with incrementing data -> one accept per frame, din_rdy low from accept until the next frame load, no underflow, and each received pair equals the pair sent, in order.
4. Period/duty check: CLK_DIV=32 -> sck high for 16 clks and low for 16 clks; ws period = 64*32 = 2048 clks; sd and ws change only in cycles where sck falls.
5. Disturbances: assert rst at bit 20 of a frame -> the next cycle shows sck=ws=sd=0 and din_rdy=1. Repeat with en=0 instead -> a buffered pair is kept and sent once en returns.
6. Loopback: feed sck/ws/sd into the team's microphone receiver, drive R=16'h1234 -> the receiver's right-channel output equals 16'h1234 once per frame.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter, one stereo pair per 64-sck frame, MSB first, one-sck delay after ws
module i2s_tx #(
  parameter int CLK_DIV = 32,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underflow
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0]     div_cnt;
  logic [5:0]        bit_cnt;
  logic [5:0]        nb;
  logic              buf_full;
  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic              adv;
  logic              load;
  assign adv     = div_cnt == CW'(CLK_DIV - 1);
  assign nb      = bit_cnt + 6'd1;
  assign load    = adv && bit_cnt == 6'd63;
  assign din_rdy = ~buf_full;
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= 6'd63;
      sck         <= 1'b0;
      ws          <= 1'b0;
      sd          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      buf_full    <= 1'b0;
      buf_l       <= '0;
      buf_r       <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
    end else begin
      if (din_vld && !buf_full) begin
        buf_full <= 1'b1;
        buf_l    <= l_data;
        buf_r    <= r_data;
      end
      if (!en) begin
        div_cnt     <= '0;
        bit_cnt     <= 6'd63;
        sck         <= 1'b0;
        ws          <= 1'b0;
        sd          <= 1'b0;
        frame_start <= 1'b0;
        underflow   <= 1'b0;
        sh_l        <= '0;
        sh_r        <= '0;
      end else begin
        div_cnt     <= adv ? '0 : div_cnt + 1'b1;
        frame_start <= load;
        underflow   <= load && !buf_full;
        if (div_cnt == CW'(CLK_DIV / 2 - 1))
          sck <= 1'b1;
        if (adv) begin
          sck     <= 1'b0;
          bit_cnt <= nb;
          ws      <= nb >= 6'd31 && nb <= 6'd62;
          if (load) begin
            sh_l <= buf_full ? buf_l << 1 : '0;
            sh_r <= buf_full ? buf_r : '0;
            sd   <= buf_full & buf_l[DATA_W-1];
            if (buf_full)
              buf_full <= 1'b0;
          end else if (nb < 6'(DATA_W)) begin
            sd   <= sh_l[DATA_W-1];
            sh_l <= sh_l << 1;
          end else if (nb >= 6'd32 && nb < 6'(32 + DATA_W)) begin
            sd   <= sh_r[DATA_W-1];
            sh_r <= sh_r << 1;
          end else begin
            sd <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with a buffer/frame scoreboard and an I2S receiver model
module tb_i2s_tx;
  localparam int CD = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din_vld = 1'b0;
  logic [DW-1:0] l_data = '0;
  logic [DW-1:0] r_data = '0;
  logic din_rdy, sck, ws, sd, frame_start, underflow;
  logic en32 = 1'b0;
  logic din_rdy32, sck32, ws32, sd32, fs32, uf32;
  i2s_tx #(.CLK_DIV(CD), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .l_data(l_data), .r_data(r_data), .din_vld(din_vld),
    .din_rdy(din_rdy), .sck(sck), .ws(ws), .sd(sd), .frame_start(frame_start), .underflow(underflow)
  );
  i2s_tx #(.CLK_DIV(32), .DATA_W(DW)) u32 (
    .clk(clk), .rst(rst), .en(en32), .l_data(16'hA5C3), .r_data(16'h0F01), .din_vld(1'b1),
    .din_rdy(din_rdy32), .sck(sck32), .ws(ws32), .sd(sd32), .frame_start(fs32), .underflow(uf32)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tmo(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask
  logic rst_q = 1'b1;
  logic en_q = 1'b0;
  logic acc_q = 1'b0;
  always @(posedge clk) begin
    rst_q = rst;
    en_q  = en;
    acc_q = !rst && din_vld && din_rdy;
  end
  logic [31:0] sent_q[$];
  logic [31:0] fq[$];
  logic [31:0] m_buf = '0;
  logic [31:0] e;
  logic m_full = 1'b0;
  logic sck_q = 1'b0;
  logic last_ws = 1'b1;
  logic ch = 1'b0;
  logic sd_one = 1'b0;
  logic [DW-1:0] sh = '0;
  logic [DW-1:0] rx_l = '0;
  int cnt = 100;
  int rx_n = 0;
  int fs_n = 0;
  int uf_n = 0;
  longint fs_t[$];
  always @(negedge clk) begin
    if (rst_q) begin
      m_full = 1'b0;
      fq.delete();
    end else if (!en_q) begin
      fq.delete();
    end
    if (rst_q || !en_q) begin
      last_ws = 1'b1;
      cnt = 100;
    end
    if (frame_start) begin
      fs_n++;
      fs_t.push_back($time);
      chk("underflow_flag", underflow, !m_full);
      fq.push_back(m_full ? m_buf : 32'h0);
      m_full = 1'b0;
    end
    if (underflow)
      uf_n++;
    if (acc_q) begin
      m_full = 1'b1;
      if (sent_q.size() != 0)
        m_buf = sent_q.pop_front();
    end
    chk("din_rdy", din_rdy, !m_full);
    if (sd)
      sd_one = 1'b1;
    if (sck && !sck_q) begin
      if (ws != last_ws) begin
        cnt = 0;
        ch = ws;
      end else begin
        cnt++;
      end
      if (cnt >= 1 && cnt <= DW)
        sh = {sh[DW-2:0], sd};
      if (cnt == DW) begin
        if (!ch) begin
          rx_l = sh;
        end else begin
          rx_n++;
          if (fq.size() == 0) begin
            tmo("rx_unexpected_frame");
          end else begin
            e = fq.pop_front();
            chk("rx_left", rx_l, e[31:16]);
            chk("rx_right", sh, e[15:0]);
          end
        end
      end
      last_ws = ws;
    end
    sck_q = sck;
  end
  logic chk32 = 1'b0;
  logic s32q = 1'b0;
  logic w32q = 1'b0;
  logic d32q = 1'b0;
  logic lo_ok = 1'b0;
  int hi = 0;
  int lo = 0;
  longint wsr_t = -1;
  always @(negedge clk) begin
    if (chk32) begin
      if (ws32 !== w32q || sd32 !== d32q)
        chk("ws_sd_change_on_sck_fall", s32q && !sck32, 1);
      if (sck32 && !s32q) begin
        if (lo_ok)
          chk("sck_low_clks", lo, 16);
        hi = 0;
      end
      if (!sck32 && s32q) begin
        chk("sck_high_clks", hi, 16);
        lo = 0;
        lo_ok = 1'b1;
      end
      if (ws32 && !w32q) begin
        if (wsr_t >= 0)
          chk("ws_period_clks", 32'(($time - wsr_t) / 10), 2048);
        wsr_t = $time;
      end
      if (sck32)
        hi++;
      else
        lo++;
    end
    s32q = sck32;
    w32q = ws32;
    d32q = sd32;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_rise();
    int n = 0;
    while (sck && n < 100) begin tick(); n++; end
    while (!sck && n < 100) begin tick(); n++; end
    if (n >= 100)
      tmo("sck_rise");
  endtask
  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < 1000) begin tick(); n++; end
    if (n >= 1000)
      tmo("frame_start");
  endtask
  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_n < target && n < 3000) begin tick(); n++; end
    if (n >= 3000)
      tmo("rx_frame");
  endtask
  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [15:0] el, input logic [15:0] er);
    int n = 0;
    din_vld = 1'b1;
    l_data = l;
    r_data = r;
    sent_q.push_back({el, er});
    while (!din_rdy && n < 2000) begin tick(); n++; end
    if (n >= 2000)
      tmo("din_rdy");
    tick();
    din_vld = 1'b0;
    l_data = 16'($urandom);
    r_data = 16'($urandom);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    din_vld = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;
  vec_t vt[6];
  initial begin
    int rx0;
    int n;
    logic exp_sd;
    logic [15:0] tl;
    logic [15:0] tr;
    vt[0] = '{16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01};
    vt[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vt[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vt[3] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    vt[4] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
    vt[5] = '{16'h0042, 16'h1234, 16'h0042, 16'h1234};
    repeat (3) tick();
    chk("reset_sck", sck, 0);
    chk("reset_ws", ws, 0);
    chk("reset_sd", sd, 0);
    chk("reset_din_rdy", din_rdy, 1);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_underflow", underflow, 0);
    rst = 1'b0;
    fs_n = 0;
    uf_n = 0;
    en = 1'b1;
    tl = 16'hA5C3;
    tr = 16'h0F01;
    send(tl, tr, tl, tr);
    wait_fs();
    for (int b = 0; b < 64; b++) begin
      wait_rise();
      exp_sd = b < 16 ? tl[15-b] : (b >= 32 && b < 48) ? tr[47-b] : 1'b0;
      chk($sformatf("frame_sd_bit%0d", b), sd, exp_sd);
      chk($sformatf("frame_ws_bit%0d", b), ws, b >= 31 && b <= 62);
    end
    chk("first_frame_start_count", fs_n, 1);
    chk("first_frame_underflow_count", uf_n, 0);
    do_reset();
    en = 1'b1;
    sd_one = 1'b0;
    fs_n = 0;
    uf_n = 0;
    fs_t.delete();
    repeat (700) tick();
    chk("idle_frame_start_count", fs_n, 3);
    chk("idle_underflow_count", uf_n, 3);
    if (fs_t.size() >= 3) begin
      chk("idle_fs_spacing0", 32'((fs_t[1] - fs_t[0]) / 10), 256);
      chk("idle_fs_spacing1", 32'((fs_t[2] - fs_t[1]) / 10), 256);
    end else begin
      tmo("idle_fs_times");
    end
    chk("idle_sd_stays_low", sd_one, 0);
    do_reset();
    en = 1'b1;
    fs_n = 0;
    uf_n = 0;
    rx0 = rx_n;
    foreach (vt[i])
      send(vt[i].l, vt[i].r, vt[i].exp_l, vt[i].exp_r);
    n = 0;
    while (fs_n < 6 && n < 3000) begin tick(); n++; end
    if (n >= 3000)
      tmo("stream_frames");
    chk("stream_underflow_count", uf_n, 0);
    wait_rx(rx0 + 6);
    do_reset();
    en = 1'b1;
    send(16'h1357, 16'h2468, 16'h1357, 16'h2468);
    wait_fs();
    send(16'h9999, 16'h6666, 16'h9999, 16'h6666);
    for (int i = 0; i < 21; i++)
      wait_rise();
    chk("pre_rst_din_rdy", din_rdy, 0);
    rst = 1'b1;
    tick();
    chk("rst_mid_sck", sck, 0);
    chk("rst_mid_ws", ws, 0);
    chk("rst_mid_sd", sd, 0);
    chk("rst_mid_din_rdy", din_rdy, 1);
    rst = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
    send(16'h1111, 16'h00FF, 16'h1111, 16'h00FF);
    wait_fs();
    send(16'hC0DE, 16'hBEEF, 16'hC0DE, 16'hBEEF);
    for (int i = 0; i < 41; i++)
      wait_rise();
    chk("pre_en_ws", ws, 1);
    chk("pre_en_sd", sd, 1);
    en = 1'b0;
    tick();
    chk("en_off_sck", sck, 0);
    chk("en_off_ws", ws, 0);
    chk("en_off_sd", sd, 0);
    chk("en_off_din_rdy_kept", din_rdy, 0);
    repeat (10) tick();
    rx0 = rx_n;
    en = 1'b1;
    wait_rx(rx0 + 1);
    en = 1'b0;
    tick();
    en32 = 1'b1;
    chk32 = 1'b1;
    repeat (3 * 2048 + 200) tick();
    chk32 = 1'b0;
    tick();
    en32 = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
